// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: link between the transmit queue and the UART_N transmitter.
//   write    : one-cycle write strobe from the queue to UART_N
//   T_W      : byte presented to UART_N, valid whenever write is high
//   T_locked : busy flag from UART_N, high while the transmitter is occupied
// master = queue side, slave = UART side.
interface uart_tx_queue_if #(
    parameter int unsigned word_width = 8
);
    logic                  write;
    logic [word_width-1:0] T_W;
    logic                  T_locked;

    modport master (
        output write,
        output T_W,
        input  T_locked
    );

    modport slave (
        input  write,
        input  T_W,
        output T_locked
    );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: circular-buffer FIFO that feeds bytes to a UART_N transmitter,
// one write pulse per byte, pacing itself on the transmitter's T_locked flag.
//
// Ports:
//   clk      : single clock, all state updates on its rising edge
//   reset    : synchronous active-high reset
//   push     : enqueue data_in this cycle
//   data_in  : byte to enqueue
//   full     : high when count == depth
//   empty    : high when count == 0
//   count    : number of stored entries
//   uart     : uart_tx_queue_if.master (write, T_W out; T_locked in)
//   overflow : sticky flag, set by a dropped push
//   clr_ovf  : clears overflow
//
// Optional feature macro: UART_TX_QUEUE_OVF_EN
//   defined   -> overflow is a sticky register set on dropped pushes
//   undefined -> overflow tied to 0, clr_ovf ignored
//
// Parameters: depth must be a power of two >= 2; lock_timeout must be >= 1.
module uart_tx_queue #(
    parameter int unsigned word_width   = 8,
    parameter int unsigned depth        = 16,
    parameter int unsigned lock_timeout = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [word_width-1:0]  data_in,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count,
    uart_tx_queue_if.master        uart,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    localparam int unsigned PTR_W = $clog2(depth);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(lock_timeout + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_LOCK = 2'd2,
        ST_WAIT_FREE = 2'd3
    } state_t;

    state_t                r_state;
    logic [word_width-1:0] r_mem [depth];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_write;
    logic [word_width-1:0] r_tw;
    logic [TMO_W-1:0]      r_tmo_cnt;

    logic                  w_deq;
    logic                  w_push_acc;
    logic [CNT_W-1:0]      w_count_nxt;

    // Dequeue uses the registered empty flag, so a push into an empty queue
    // is only seen by the FSM one cycle later.
    assign w_deq       = (r_state == ST_IDLE) && !r_empty && !uart.T_locked;
    // A full queue still accepts a push when a slot frees up in the same cycle.
    assign w_push_acc  = push && (!r_full || w_deq);
    assign w_count_nxt = r_count + CNT_W'(w_push_acc) - CNT_W'(w_deq);

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since depth is 2^n.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(depth));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Transmit FSM: hand one byte over, then wait for UART_N to take and
    // release it (or give up after lock_timeout cycles without a lock).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_write   <= 1'b0;
            r_tw      <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_deq) begin
                        r_tw    <= r_mem[r_rd_ptr];
                        r_write <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (uart.T_locked) begin
                        r_state <= ST_WAIT_FREE;
                    end else if (r_tmo_cnt >= TMO_W'(lock_timeout - 1)) begin
                        // Transmitter never acknowledged; treat the byte as sent.
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                ST_WAIT_FREE: begin
                    if (!uart.T_locked) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign full       = r_full;
    assign empty      = r_empty;
    assign count      = r_count;
    assign uart.write = r_write;
    assign uart.T_W   = r_tw;

`ifdef UART_TX_QUEUE_OVF_EN
    logic r_overflow;
    logic w_drop;

    assign w_drop = push && !w_push_acc;

    // A drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;
`else
    logic w_unused_clr_ovf;

    assign w_unused_clr_ovf = clr_ovf;
    assign overflow         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios plus a randomized
// phase, all compared cycle by cycle against a transaction-level model.
module tb_uart_tx_queue;

    localparam int unsigned WW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 15;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   push;
    logic [WW-1:0]          data_in;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   clr_ovf;

    always #5 clk = ~clk;

    uart_tx_queue_if #(.word_width(WW)) u_if ();

    uart_tx_queue #(
        .word_width  (WW),
        .depth       (DEPTH),
        .lock_timeout(TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .data_in (data_in),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .uart    (u_if),
        .overflow(overflow),
        .clr_ovf (clr_ovf)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: queue contents plus a "transmitter busy" window that
    // opens at a dequeue and closes on lock release or on timeout.
    logic [WW-1:0] m_q[$];
    logic [WW-1:0] m_tw     = '0;
    bit            m_wr     = 1'b0;
    bit            m_ovf    = 1'b0;
    bit            m_busy   = 1'b0;
    bit            m_locked = 1'b0;
    int            m_wcyc   = 0;

    // UART_N emulation
    int lk_mode = 0;
    int lk_hold = 10;
    int lk_ctr  = 0;

    // observed write pulses
    int            wr_cyc_q[$];
    logic [WW-1:0] wr_dat_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance the model across the edge that ends cycle 'cyc'.
    task automatic model_edge();
        bit tl;
        bit deq;
        bit acc;
        tl = u_if.T_locked;
        if (reset) begin
            m_q.delete();
            m_tw     = '0;
            m_wr     = 1'b0;
            m_ovf    = 1'b0;
            m_busy   = 1'b0;
            m_locked = 1'b0;
            return;
        end
        deq = !m_busy && (m_q.size() > 0) && !tl;
        if (m_busy && cyc > m_wcyc) begin
            if (!m_locked) begin
                if (tl) m_locked = 1'b1;
                else if (cyc - m_wcyc == int'(TMO)) m_busy = 1'b0;
            end else if (!tl) begin
                m_busy = 1'b0;
            end
        end
        m_wr = deq;
        if (deq) begin
            m_tw     = m_q.pop_front();
            m_busy   = 1'b1;
            m_wcyc   = cyc + 1;
            m_locked = 1'b0;
        end
        acc = push && (m_q.size() < int'(DEPTH));
        if (acc) m_q.push_back(data_in);
`ifdef UART_TX_QUEUE_OVF_EN
        if (push && !acc) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
`endif
    endtask

    task automatic drive_lock();
        case (lk_mode)
            0: u_if.T_locked = 1'b0;
            1: u_if.T_locked = 1'b1;
            2: begin
                if (m_wr) lk_ctr = lk_hold;
                u_if.T_locked = (lk_ctr > 0);
                if (lk_ctr > 0) lk_ctr--;
            end
            default: u_if.T_locked = ($urandom_range(0, 2) == 0);
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("write",    {31'd0, u_if.write}, {31'd0, m_wr});
        chk("T_W",      32'(u_if.T_W), 32'(m_tw));
        chk("count",    32'(count), m_q.size());
        chk("full",     {31'd0, full},  {31'd0, m_q.size() == int'(DEPTH)});
        chk("empty",    {31'd0, empty}, {31'd0, m_q.size() == 0});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (u_if.write === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            wr_dat_q.push_back(u_if.T_W);
        end
    endtask

    task automatic tick(input bit p, input logic [WW-1:0] d);
        push    = p;
        data_in = d;
        drive_lock();
        step();
        push    = 1'b0;
    endtask

    task automatic clear_log();
        wr_cyc_q.delete();
        wr_dat_q.delete();
    endtask

    initial begin
        int p_cyc;
        int n;
        reset         = 1'b1;
        push          = 1'b0;
        clr_ovf       = 1'b0;
        data_in       = '0;
        u_if.T_locked = 1'b0;

        // reset
        tick(1'b0, '0);
        tick(1'b0, '0);
        reset = 1'b0;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_tw",    32'(u_if.T_W), 32'd0);

        // single byte: write two cycles after the push
        clear_log();
        p_cyc = cyc;
        tick(1'b1, 8'hA5);
        repeat (25) tick(1'b0, '0);
        chk("a5_npulse", wr_cyc_q.size(), 32'd1);
        chk("a5_lat",    (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - p_cyc : -1, 32'd2);
        chk("a5_data",   (wr_dat_q.size() > 0) ? 32'(wr_dat_q[0]) : 32'hFFFF, 32'hA5);
        chk("a5_count",  32'(count), 32'd0);

        // fill while the transmitter is busy, then one extra push is dropped
        lk_mode = 1;
        for (int i = 0; i < int'(DEPTH); i++) tick(1'b1, WW'(i));
        chk("fill_full",  {31'd0, full}, 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        tick(1'b1, 8'hFF);
        chk("drop_count", 32'(count), 32'd16);
`ifdef UART_TX_QUEUE_OVF_EN
        chk("drop_ovf", {31'd0, overflow}, 32'd1);
`endif

        // drain with a responsive transmitter
        clear_log();
        lk_mode = 2;
        lk_hold = 10;
        for (int i = 0; i < 400; i++) begin
            if (wr_dat_q.size() >= int'(DEPTH) && m_q.size() == 0) break;
            tick(1'b0, '0);
        end
        repeat (20) tick(1'b0, '0);
        chk("drain_npulse", wr_dat_q.size(), DEPTH);
        for (int k = 0; k < int'(DEPTH); k++)
            chk("drain_order", (k < wr_dat_q.size()) ? 32'(wr_dat_q[k]) : 32'hFFFF, 32'(k));
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // push into a full queue in the same cycle as a dequeue
        clr_ovf = 1'b1;
        tick(1'b0, '0);
        clr_ovf = 1'b0;
        lk_mode = 1;
        for (int i = 0; i < int'(DEPTH); i++) tick(1'b1, WW'($urandom));
        clear_log();
        lk_mode = 0;
        tick(1'b1, 8'h77);
        chk("bnd_count", 32'(count), 32'd16);
        chk("bnd_ovf",   {31'd0, overflow}, 32'd0);
        lk_mode = 2;
        lk_hold = 2;
        for (int i = 0; i < 300; i++) begin
            if (m_q.size() == 0) break;
            tick(1'b0, '0);
        end
        repeat (20) tick(1'b0, '0);
        n = wr_dat_q.size();
        chk("bnd_npulse", n, 32'd17);
        chk("bnd_last",   (n > 0) ? 32'(wr_dat_q[n-1]) : 32'hFFFF, 32'h77);

        // lock timeout spacing
        clear_log();
        lk_mode = 0;
        tick(1'b1, 8'h3C);
        tick(1'b1, 8'h3D);
        repeat (50) tick(1'b0, '0);
        chk("tmo_npulse", wr_cyc_q.size(), 32'd2);
        chk("tmo_space",  (wr_cyc_q.size() > 1) ? wr_cyc_q[1] - wr_cyc_q[0] : -1, TMO + 2);
        chk("tmo_data",   (wr_dat_q.size() > 1) ? 32'(wr_dat_q[1]) : 32'hFFFF, 32'h3D);

        // reset while waiting for the transmitter to free up
        lk_mode = 2;
        lk_hold = 30;
        for (int i = 0; i < 6; i++) tick(1'b1, WW'($urandom));
        tick(1'b0, '0);
        chk("mid_pre_count", 32'(count), 32'd5);
        reset = 1'b1;
        tick(1'b0, '0);
        reset = 1'b0;
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_write", {31'd0, u_if.write}, 32'd0);
        clear_log();
        repeat (60) tick(1'b0, '0);
        chk("mid_nopulse", wr_cyc_q.size(), 32'd0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (i % 60 == 0) begin
                lk_mode = $urandom_range(0, 3);
                lk_hold = $urandom_range(0, 4);
            end
            reset   = ($urandom_range(0, 299) == 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            tick($urandom_range(0, 2) != 0, WW'($urandom));
        end
        reset   = 1'b0;
        clr_ovf = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
